// File: rtl/axi_lite_slave_mem.sv
// axi_lite_slave_mem
// AXI4-Lite responder backed by a word-addressed register memory.
// Independent write and read engines: AW and W may arrive in either order,
// and one read is serviced concurrently with one write.
//
// Optional feature macro: AXI_LITE_SLV_ERR_EN
//   defined     : addresses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) are
//                 rejected with SLVERR (writes dropped, reads return 0).
//   not defined : the word index wraps modulo DEPTH, every response is OKAY.
//
// Ports
//   ACLK, ARESET                  clock, synchronous active-high reset
//   AWADDR/AWPROT/AWVALID/AWREADY write address channel (AWPROT ignored)
//   WDATA/WSTRB/WVALID/WREADY     write data channel
//   BRESP/BVALID/BREADY           write response channel
//   ARADDR/ARPROT/ARVALID/ARREADY read address channel (ARPROT ignored)
//   RDATA/RRESP/RVALID/RREADY     read data channel

module axi_lite_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,

    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,

    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,

    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,

    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,

    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_D, W_WAIT_A, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;

    logic                  commit_en;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb;
    logic [ADDR_WIDTH-1:0] commit_off;
    logic [IDX_W-1:0]      commit_idx;
    logic                  wr_in_range;
    logic [1:0]            wr_resp;

    logic [ADDR_WIDTH-1:0] rd_off;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;

    // Ready outputs decode from state only; reset masks them so an
    // initiator never sees ready while ARESET is high.
    assign AWREADY = !ARESET && (w_state == W_IDLE || w_state == W_WAIT_A);
    assign WREADY  = !ARESET && (w_state == W_IDLE || w_state == W_WAIT_D);
    assign ARREADY = !ARESET && (r_state == R_IDLE);

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // Select the address/data/strobe of the write that completes this cycle:
    // whichever half arrived earlier comes from its holding register.
    always_comb begin
        commit_en   = 1'b0;
        commit_addr = awaddr_q;
        commit_data = wdata_q;
        commit_strb = wstrb_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit_en   = 1'b1;
                    commit_addr = AWADDR;
                    commit_data = WDATA;
                    commit_strb = WSTRB;
                end
            end
            W_WAIT_D: begin
                if (w_hs) begin
                    commit_en   = 1'b1;
                    commit_data = WDATA;
                    commit_strb = WSTRB;
                end
            end
            W_WAIT_A: begin
                if (aw_hs) begin
                    commit_en   = 1'b1;
                    commit_addr = AWADDR;
                end
            end
            default: ;
        endcase
    end

    // Byte offset from the window base; bits [1:0] are ignored, the next
    // IDX_W bits are the word index (so out-of-window addresses wrap).
    assign commit_off = commit_addr - BASE_ADDR;
    assign commit_idx = commit_off[IDX_W+1:2];
    assign rd_off     = ARADDR - BASE_ADDR;
    assign rd_idx     = rd_off[IDX_W+1:2];

`ifdef AXI_LITE_SLV_ERR_EN
    // Subtraction is unsigned, so addresses below BASE_ADDR wrap to a large
    // offset and fail the same upper-bits test.
    assign wr_in_range = (commit_off[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign rd_in_range = (rd_off[ADDR_WIDTH-1:IDX_W+2] == '0);
`else
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
`endif

    assign wr_resp = wr_in_range ? RESP_OKAY : RESP_SLVERR;

    // Write engine: holds whichever channel arrives first, then issues a
    // single B beat once both halves are in.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state  <= W_IDLE;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit_en) begin
                        w_state <= W_RESP;
                        BVALID  <= 1'b1;
                        BRESP   <= wr_resp;
                    end else if (aw_hs) begin
                        awaddr_q <= AWADDR;
                        w_state  <= W_WAIT_D;
                    end else if (w_hs) begin
                        wdata_q <= WDATA;
                        wstrb_q <= WSTRB;
                        w_state <= W_WAIT_A;
                    end
                end
                W_WAIT_D, W_WAIT_A: begin
                    if (commit_en) begin
                        w_state <= W_RESP;
                        BVALID  <= 1'b1;
                        BRESP   <= wr_resp;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory array is deliberately not reset. Being a separate nonblocking
    // update, a read of the same word in the same cycle sees the old value.
    always_ff @(posedge ACLK) begin
        if (commit_en && wr_in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (commit_strb[i]) begin
                    mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
                end
            end
        end
    end

    // Read engine: one outstanding read, data registered at AR handshake
    // and held until the R handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            RVALID  <= 1'b0;
            RRESP   <= RESP_OKAY;
            RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        RVALID  <= 1'b1;
                        RDATA   <= rd_in_range ? mem[rd_idx] : '0;
                        RRESP   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Protection bits and low address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, commit_off, rd_off};

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb_axi_lite_slave_mem
// Directed self-checking bench for axi_lite_slave_mem (default parameters).
// Expectations for out-of-range accesses follow AXI_LITE_SLV_ERR_EN.

module tb_axi_lite_slave_mem;

    logic        ACLK;
    logic        ARESET;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int check_count = 0;
    int error_count = 0;

    axi_lite_slave_mem dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs are driven and outputs sampled 1 unit after each rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Write with AW and W presented together; B accepted one cycle later.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] exp_resp,
                              input string tag);
        AWADDR  = addr;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        checkOutput({tag, " awready"}, 32'(AWREADY), 32'd1);
        checkOutput({tag, " wready"}, 32'(WREADY), 32'd1);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        checkOutput({tag, " bvalid"}, 32'(BVALID), 32'd1);
        checkOutput({tag, " bresp"}, 32'(BRESP), 32'(exp_resp));
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        checkOutput({tag, " bvalid clear"}, 32'(BVALID), 32'd0);
    endtask

    task automatic read_word(input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic [1:0] exp_resp, input string tag);
        ARADDR  = addr;
        ARVALID = 1'b1;
        checkOutput({tag, " arready"}, 32'(ARREADY), 32'd1);
        tick();
        ARVALID = 1'b0;
        checkOutput({tag, " rvalid"}, 32'(RVALID), 32'd1);
        checkOutput({tag, " rdata"}, RDATA, exp_data);
        checkOutput({tag, " rresp"}, 32'(RRESP), 32'(exp_resp));
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        checkOutput({tag, " rvalid clear"}, 32'(RVALID), 32'd0);
    endtask

    // Directed sequence: reset, basic write/read, channel ordering, strobes,
    // backpressure with same-cycle read/write, out-of-range, reset drop.
    task automatic applyStimulus();
        ARESET  = 1'b1;
        AWADDR  = '0;
        AWPROT  = '0;
        AWVALID = 1'b0;
        WDATA   = '0;
        WSTRB   = '0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        ARADDR  = '0;
        ARPROT  = '0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset awready", 32'(AWREADY), 32'd0);
            checkOutput("reset wready", 32'(WREADY), 32'd0);
            checkOutput("reset arready", 32'(ARREADY), 32'd0);
            checkOutput("reset bvalid", 32'(BVALID), 32'd0);
            checkOutput("reset rvalid", 32'(RVALID), 32'd0);
        end
        ARESET = 1'b0;
        #1;
        checkOutput("release awready", 32'(AWREADY), 32'd1);
        checkOutput("release wready", 32'(WREADY), 32'd1);
        checkOutput("release arready", 32'(ARREADY), 32'd1);
        checkOutput("release bresp", 32'(BRESP), 32'd0);
        checkOutput("release rresp", 32'(RRESP), 32'd0);
        checkOutput("release rdata", RDATA, 32'd0);

        write_word(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, "wr10");
        read_word(32'h10, 32'hDEADBEEF, 2'b00, "rd10");

        // W three cycles ahead of AW
        write_word(32'h30, 32'h01010101, 4'hF, 2'b00, "pre30");
        WDATA  = 32'hCAFEF00D;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        checkOutput("wfirst wready", 32'(WREADY), 32'd0);
        checkOutput("wfirst awready", 32'(AWREADY), 32'd1);
        checkOutput("wfirst bvalid early", 32'(BVALID), 32'd0);
        read_word(32'h30, 32'h01010101, 2'b00, "wfirst old");
        checkOutput("wfirst bvalid wait", 32'(BVALID), 32'd0);
        AWADDR  = 32'h30;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        checkOutput("wfirst bvalid", 32'(BVALID), 32'd1);
        checkOutput("wfirst bresp", 32'(BRESP), 32'd0);
        BREADY = 1'b1;
        tick();
        checkOutput("wfirst single beat", 32'(BVALID), 32'd0);
        tick();
        BREADY = 1'b0;
        checkOutput("wfirst no extra beat", 32'(BVALID), 32'd0);
        read_word(32'h30, 32'hCAFEF00D, 2'b00, "wfirst new");

        // AW three cycles ahead of W
        write_word(32'h34, 32'h02020202, 4'hF, 2'b00, "pre34");
        AWADDR  = 32'h34;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        checkOutput("awfirst awready", 32'(AWREADY), 32'd0);
        checkOutput("awfirst wready", 32'(WREADY), 32'd1);
        checkOutput("awfirst bvalid early", 32'(BVALID), 32'd0);
        read_word(32'h34, 32'h02020202, 2'b00, "awfirst old");
        WDATA  = 32'h12345678;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        checkOutput("awfirst bvalid", 32'(BVALID), 32'd1);
        BREADY = 1'b1;
        tick();
        checkOutput("awfirst single beat", 32'(BVALID), 32'd0);
        tick();
        BREADY = 1'b0;
        checkOutput("awfirst no extra beat", 32'(BVALID), 32'd0);
        read_word(32'h34, 32'h12345678, 2'b00, "awfirst new");

        // Byte strobes: lanes 0 and 2 replaced, zero strobe writes nothing
        write_word(32'h20, 32'h11223344, 4'hF, 2'b00, "pre20");
        write_word(32'h20, 32'hAABBCCDD, 4'b0101, 2'b00, "strb0101");
        read_word(32'h20, 32'h11BB33DD, 2'b00, "rd strb0101");
        write_word(32'h20, 32'hFFFFFFFF, 4'b0000, 2'b00, "strb0000");
        read_word(32'h20, 32'h11BB33DD, 2'b00, "rd strb0000");

        // Same-cycle read and write of one word, then both responses stalled
        write_word(32'h40, 32'h55555555, 4'hF, 2'b00, "pre40");
        AWADDR  = 32'h40;
        WDATA   = 32'h66666666;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        ARADDR  = 32'h40;
        ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp bvalid", 32'(BVALID), 32'd1);
            checkOutput("bp bresp", 32'(BRESP), 32'd0);
            checkOutput("bp rvalid", 32'(RVALID), 32'd1);
            checkOutput("bp rdata old", RDATA, 32'h55555555);
            checkOutput("bp rresp", 32'(RRESP), 32'd0);
            checkOutput("bp awready", 32'(AWREADY), 32'd0);
            checkOutput("bp wready", 32'(WREADY), 32'd0);
            checkOutput("bp arready", 32'(ARREADY), 32'd0);
            tick();
        end
        BREADY = 1'b1;
        RREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        RREADY = 1'b0;
        checkOutput("bp bvalid clear", 32'(BVALID), 32'd0);
        checkOutput("bp rvalid clear", 32'(RVALID), 32'd0);
        checkOutput("bp awready back", 32'(AWREADY), 32'd1);
        checkOutput("bp arready back", 32'(ARREADY), 32'd1);
        read_word(32'h40, 32'h66666666, 2'b00, "rd40 new");

        // Out of range at 0x400 (one past the last word)
        write_word(32'h0, 32'hA5A5A5A5, 4'hF, 2'b00, "pre0");
`ifdef AXI_LITE_SLV_ERR_EN
        write_word(32'h400, 32'h77777777, 4'hF, 2'b10, "oor wr");
        read_word(32'h0, 32'hA5A5A5A5, 2'b00, "oor word0");
        read_word(32'h400, 32'h00000000, 2'b10, "oor rd");
`else
        write_word(32'h400, 32'h77777777, 4'hF, 2'b00, "wrap wr");
        read_word(32'h0, 32'h77777777, 2'b00, "wrap word0");
        read_word(32'h400, 32'h77777777, 2'b00, "wrap rd");
`endif

        // Reset while a write is half-accepted and a read beat is pending
        AWADDR  = 32'h50;
        AWVALID = 1'b1;
        ARADDR  = 32'h10;
        ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        ARVALID = 1'b0;
        checkOutput("drop pre awready", 32'(AWREADY), 32'd0);
        checkOutput("drop pre rvalid", 32'(RVALID), 32'd1);
        ARESET = 1'b1;
        #1;
        checkOutput("drop awready", 32'(AWREADY), 32'd0);
        checkOutput("drop wready", 32'(WREADY), 32'd0);
        checkOutput("drop arready", 32'(ARREADY), 32'd0);
        tick();
        checkOutput("drop rvalid", 32'(RVALID), 32'd0);
        checkOutput("drop bvalid", 32'(BVALID), 32'd0);
        checkOutput("drop rdata", RDATA, 32'd0);
        ARESET = 1'b0;
        #1;
        checkOutput("drop release awready", 32'(AWREADY), 32'd1);
        checkOutput("drop release wready", 32'(WREADY), 32'd1);
        WDATA  = 32'h0BADF00D;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        checkOutput("drop no commit", 32'(BVALID), 32'd0);
        checkOutput("drop waits aw", 32'(WREADY), 32'd0);
        AWADDR  = 32'h50;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        checkOutput("drop new bvalid", 32'(BVALID), 32'd1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        read_word(32'h50, 32'h0BADF00D, 2'b00, "rd50");
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
